// File: rtl/pc_ctrl_if.sv
// Program-counter unit bus: redirect requests from D stage / CP0 in, fetch state out.
interface pc_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  // Control from hazard/branch logic and CP0
  logic              en;
  logic [WIDTH-1:0]  ctl_pc;
  logic              br_take;
  logic [15:0]       br_off;
  logic              j_take;
  logic [25:0]       j_index;
  logic              jr_take;
  logic [WIDTH-1:0]  jr_target;
  logic              exc_req;
  logic [WIDTH-1:0]  exc_epc;
  logic              eret;

  // Fetch-side state
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  epc;
  logic              pend;
  logic              fetch_fault;

  // Pipeline/CP0 side: drives redirects, observes the PC.
  modport master (
    output en, ctl_pc, br_take, br_off, j_take, j_index,
           jr_take, jr_target, exc_req, exc_epc, eret,
    input  pc, epc, pend, fetch_fault
  );

  // PC unit side.
  modport slave (
    input  en, ctl_pc, br_take, br_off, j_take, j_index,
           jr_take, jr_target, exc_req, exc_epc, eret,
    output pc, epc, pend, fetch_fault
  );
endinterface

// File: rtl/pc_ctrl.sv
// Pipelined program-counter unit: next-PC selection, EPC, stall-time redirect buffer,
// and fetch-address fault detection.
module pc_ctrl #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] IM_BASE   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] IM_BYTES  = WIDTH'(32'h0000_4000)
) (
  input logic         clk,
  input logic         reset,
  pc_ctrl_if.slave    bus
);

  localparam int unsigned SEXT_W = WIDTH - 18;

  // One bit wider so a window ending at 2^WIDTH does not wrap.
  localparam logic [WIDTH:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  // Jump concatenation needs the top 4+ address bits above the 28-bit region.
  if (WIDTH < 32) begin : g_width_check
    $error("pc_ctrl: WIDTH must be >= 32");
  end

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

  logic [WIDTH-1:0] seq_tgt;
  logic [WIDTH-1:0] ctl_next;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic             redir;
  logic [WIDTH-1:0] tgt;
  logic             fault_c;

  // Candidate targets, all modulo 2^WIDTH.
  assign seq_tgt  = pc_q + WIDTH'(4);
  assign ctl_next = bus.ctl_pc + WIDTH'(4);
  assign br_tgt   = ctl_next + {{SEXT_W{bus.br_off[15]}}, bus.br_off, 2'b00};
  assign j_tgt    = {ctl_next[WIDTH-1:28], bus.j_index, 2'b00};

  // Highest-priority redirect target; exception vector wins over everything.
  always_comb begin
    redir = bus.exc_req | bus.eret | bus.jr_take | bus.j_take | bus.br_take;
    tgt   = seq_tgt;
    if (bus.exc_req)      tgt = EXC_VEC;
    else if (bus.eret)    tgt = epc_q;
    else if (bus.jr_take) tgt = bus.jr_target;
    else if (bus.j_take)  tgt = j_tgt;
    else if (bus.br_take) tgt = br_tgt;
  end

  // Next-state: exceptions ignore the stall; otherwise advance or buffer the redirect.
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (bus.exc_req) begin
      pc_d   = EXC_VEC;
      epc_d  = {bus.exc_epc[WIDTH-1:2], 2'b00};
      pend_d = 1'b0;
    end else if (bus.en) begin
      pend_d = 1'b0;
      if (redir)       pc_d = tgt;
      else if (pend_q) pc_d = pend_pc_q;
      else             pc_d = seq_tgt;
    end else if (redir) begin
      pend_d    = 1'b1;
      pend_pc_d = tgt;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Fetch fault: misaligned, below the IM window, or at/after its end.
  always_comb begin
    fault_c = (pc_q[1:0] != 2'b00) ||
              (pc_q < IM_BASE) ||
              ({1'b0, pc_q} >= IM_END);
  end

  assign bus.pc          = pc_q;
  assign bus.epc         = epc_q;
  assign bus.pend        = pend_q;
  assign bus.fetch_fault = fault_c;

endmodule
